// File: rtl/usb_stream_bridge.sv
// FX2 slave-FIFO bridge: reads an EP2 packet, streams it out, collects a response
// stream and writes it to EP6. Define USB_LOOPBACK_EN to echo EP2 packets to EP6 directly.
module usb_stream_bridge #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 256
) (
  input  logic                  i_usb_ifclk,
  input  logic                  i_rst_n,
  input  logic                  i_usb_flaga,
  input  logic                  i_usb_flagd,
  inout  wire  [DATA_WIDTH-1:0] io_usb_data,
  output logic [1:0]            o_usb_addr,
  output logic                  o_usb_slrd,
  output logic                  o_usb_slwr,
  output logic                  o_usb_sloe,
  output logic                  o_usb_pkend,
  output logic [DATA_WIDTH-1:0] o_rx_data,
  output logic                  o_rx_valid,
  output logic                  o_rx_last,
  input  logic                  i_rx_ready,
  input  logic [DATA_WIDTH-1:0] i_tx_data,
  input  logic                  i_tx_valid,
  input  logic                  i_tx_last,
  output logic                  o_tx_ready,
  output logic [2:0]            o_dbg_state
);
  localparam int AW = $clog2(DEPTH) + 1;
  localparam int IW = AW - 1;
  localparam logic [AW-1:0] DEPTH_W = AW'(DEPTH);
  localparam logic [AW-1:0] ONE     = AW'(1);

  typedef enum logic [2:0] {
    IDLE, RD_SEL, RD, RX_STREAM, TX_STREAM, WR_SEL, WR, PKTEND
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d, idx_q, idx_d, len_q, len_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rd_word, mem_wdata;
  logic            mem_we, drive, rx_valid, rx_last, tx_ready;

  assign rd_word = mem_q[idx_q[IW-1:0]];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    len_d       = len_q;
    o_usb_addr  = 2'b00;
    o_usb_slrd  = 1'b1;
    o_usb_slwr  = 1'b1;
    o_usb_sloe  = 1'b1;
    o_usb_pkend = 1'b1;
    drive       = 1'b0;
    rx_valid    = 1'b0;
    rx_last     = 1'b0;
    tx_ready    = 1'b0;
    mem_we      = 1'b0;
    mem_wdata   = io_usb_data;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (i_usb_flaga) state_d = RD_SEL;
      end
      RD_SEL: begin
        o_usb_sloe = 1'b0;
        state_d    = RD;
      end
      RD: begin
        o_usb_sloe = 1'b0;
        if (i_usb_flaga && (cnt_q < DEPTH_W)) begin
          o_usb_slrd = 1'b0;
          mem_we     = 1'b1;
          cnt_d      = cnt_q + ONE;
        end else begin
          len_d = cnt_q;
          cnt_d = '0;
          if (cnt_q == '0) state_d = IDLE;
`ifdef USB_LOOPBACK_EN
          else state_d = WR_SEL;
`else
          else state_d = RX_STREAM;
`endif
        end
      end
      RX_STREAM: begin
        rx_valid = 1'b1;
        rx_last  = (idx_q == len_q - ONE);
        if (i_rx_ready) begin
          if (rx_last) begin
            idx_d   = '0;
            state_d = TX_STREAM;
          end else begin
            idx_d = idx_q + ONE;
          end
        end
      end
      TX_STREAM: begin
        // Response overwrites the buffer from word 0; the request has been fully drained.
        tx_ready  = (cnt_q < DEPTH_W);
        mem_wdata = i_tx_data;
        if (i_tx_valid && tx_ready) begin
          mem_we = 1'b1;
          cnt_d  = cnt_q + ONE;
          if (i_tx_last || (cnt_q == DEPTH_W - ONE)) begin
            len_d   = cnt_q + ONE;
            state_d = WR_SEL;
          end
        end
      end
      WR_SEL: begin
        o_usb_addr = 2'b10;
        drive      = 1'b1;
        if (i_usb_flagd) state_d = WR;
      end
      WR: begin
        o_usb_addr = 2'b10;
        drive      = 1'b1;
        if (i_usb_flagd) begin
          o_usb_slwr = 1'b0;
          idx_d      = idx_q + ONE;
          if (idx_q == len_q - ONE) state_d = PKTEND;
        end
      end
      PKTEND: begin
        // A full packet is committed by the FX2 itself, so pkend is only for short ones.
        o_usb_addr  = 2'b10;
        o_usb_pkend = (len_q == DEPTH_W);
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_usb_ifclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
    end
  end

  always_ff @(posedge i_usb_ifclk) begin
    if (mem_we) mem_q[cnt_q[IW-1:0]] <= mem_wdata;
  end

  assign io_usb_data = drive ? rd_word : {DATA_WIDTH{1'bz}};
  assign o_rx_data   = rd_word;
  assign o_dbg_state = state_q;

`ifdef USB_LOOPBACK_EN
  assign o_rx_valid = 1'b0;
  assign o_rx_last  = 1'b0;
  assign o_tx_ready = 1'b0;
`else
  assign o_rx_valid = rx_valid;
  assign o_rx_last  = rx_last;
  assign o_tx_ready = tx_ready;
`endif
endmodule
